// File: rtl/pc_ras_unit.sv
// PC sequencer with branch/jump/call/return steering and a circular
// return-address stack with sticky overflow/underflow flags.
module pc_ras_unit #(
    parameter int WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h00400020),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h80000180),
    parameter int RAS_DEPTH = 4,
    localparam int CW = $clog2(RAS_DEPTH + 1),
    localparam int PW = $clog2(RAS_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exception,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [25:0]      jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [CW-1:0]    ras_count,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    logic [WIDTH-1:0] r_pc;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_top;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_stack [RAS_DEPTH];

    logic [WIDTH-1:0] w_pc4;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_jmp_tgt;
    logic [PW-1:0]    w_top_p1;
    logic [PW-1:0]    w_top_m1;
    logic             w_full;
    logic             w_empty;
    logic             w_active;
    logic             w_push;

    assign w_pc4     = r_pc + WIDTH'(4);
    assign w_br_tgt  = w_pc4 + {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign w_jmp_tgt = {w_pc4[WIDTH-1:28], jump_target, 2'b00};

    // r_top is the next free slot; when full it also holds the oldest entry
    assign w_top_p1 = (r_top == PW'(RAS_DEPTH - 1)) ? '0 : r_top + PW'(1);
    assign w_top_m1 = (r_top == '0) ? PW'(RAS_DEPTH - 1) : r_top - PW'(1);
    assign w_full   = (r_count == CW'(RAS_DEPTH));
    assign w_empty  = (r_count == '0);

    assign w_active = !reset && !exception && !stall;
    assign w_push   = w_active && !ret && call;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_VEC;
            r_count <= '0;
            r_top   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (exception) begin
            r_pc <= EXC_VEC;
        end else if (!stall) begin
            if (ret) begin
                if (!w_empty) begin
                    r_pc    <= r_stack[w_top_m1];
                    r_top   <= w_top_m1;
                    r_count <= r_count - CW'(1);
                end else begin
                    r_pc  <= w_pc4;
                    r_unf <= 1'b1;
                end
            end else if (call) begin
                r_pc  <= w_jmp_tgt;
                r_top <= w_top_p1;
                if (w_full) r_ovf <= 1'b1;
                else        r_count <= r_count + CW'(1);
            end else if (jump) begin
                r_pc <= w_jmp_tgt;
            end else if (branch_taken) begin
                r_pc <= w_br_tgt;
            end else begin
                r_pc <= w_pc4;
            end
        end
    end

    // Stack storage carries no reset; validity is tracked by r_count only
    always_ff @(posedge clk) begin
        if (w_push) r_stack[r_top] <= w_pc4;
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc4;
    assign ras_count     = r_count;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: stimulus queues expectations,
// a monitor pops and compares one entry after every clock edge.
module tb_pc_ras_unit;

    logic        clk = 1'b0;
    logic        reset, stall, exception, branch_taken;
    logic [15:0] branch_offset;
    logic        jump, call, ret;
    logic [25:0] jump_target;
    logic [31:0] pc, pc_plus4;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
        string       name;
    } exp_t;

    exp_t q[$];

    pc_ras_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .exception(exception),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
        .pc(pc), .pc_plus4(pc_plus4), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, f, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "pc", pc, e.pc);
            chk(e.name, "pc_plus4", pc_plus4, e.pc + 32'd4);
            chk(e.name, "ras_count", {29'd0, ras_count}, {29'd0, e.cnt});
            chk(e.name, "ovf", {31'd0, ras_overflow}, {31'd0, e.ovf});
            chk(e.name, "unf", {31'd0, ras_underflow}, {31'd0, e.unf});
        end
    end

    task automatic clr();
        reset = 0; stall = 0; exception = 0; branch_taken = 0;
        branch_offset = 16'h0; jump = 0; call = 0; ret = 0;
        jump_target = 26'h0;
    endtask

    task automatic step(input logic [31:0] p, input logic [2:0] c,
                        input logic o, input logic u, input string n);
        exp_t e;
        e.pc = p; e.cnt = c; e.ovf = o; e.unf = u; e.name = n;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        clr();
    endtask

    task automatic do_call(input logic [25:0] jt);
        call = 1; jump_target = jt;
    endtask

    initial begin
        clr();
        reset = 1;
        step(32'h00400020, 0, 0, 0, "reset");
        step(32'h00400024, 0, 0, 0, "idle1");
        step(32'h00400028, 0, 0, 0, "idle2");
        step(32'h0040002C, 0, 0, 0, "idle3");
        step(32'h00400030, 0, 0, 0, "idle4");
        branch_taken = 1; branch_offset = 16'hFFFC;
        step(32'h00400024, 0, 0, 0, "br_neg");
        step(32'h00400028, 0, 0, 0, "idle5");
        step(32'h0040002C, 0, 0, 0, "idle6");
        step(32'h00400030, 0, 0, 0, "idle7");
        branch_taken = 1; branch_offset = 16'h0003;
        step(32'h00400040, 0, 0, 0, "br_pos");
        do_call(26'h0100080);
        step(32'h00400200, 1, 0, 0, "call1");
        ret = 1;
        step(32'h00400044, 0, 0, 0, "ret1");

        do_call(26'h0100100); step(32'h00400400, 1, 0, 0, "ncall1");
        do_call(26'h0100200); step(32'h00400800, 2, 0, 0, "ncall2");
        do_call(26'h0100300); step(32'h00400C00, 3, 0, 0, "ncall3");
        do_call(26'h0100400); step(32'h00401000, 4, 0, 0, "ncall4");
        do_call(26'h0100500); step(32'h00401400, 4, 1, 0, "ncall5_ovf");
        ret = 1; step(32'h00401004, 3, 1, 0, "nret1");
        ret = 1; step(32'h00400C04, 2, 1, 0, "nret2");
        ret = 1; step(32'h00400804, 1, 1, 0, "nret3");
        ret = 1; step(32'h00400404, 0, 1, 0, "nret4");
        ret = 1; step(32'h00400408, 0, 1, 1, "nret5_unf");

        do_call(26'h0100100); step(32'h00400400, 1, 1, 1, "scall");
        for (int i = 0; i < 3; i++) begin
            stall = 1; branch_taken = 1; branch_offset = 16'h0003;
            step(32'h00400400, 1, 1, 1, "stall_br");
        end
        stall = 1; do_call(26'h0100200);
        step(32'h00400400, 1, 1, 1, "stall_call");
        stall = 1; ret = 1;
        step(32'h00400400, 1, 1, 1, "stall_ret");
        stall = 1; exception = 1; ret = 1;
        step(32'h80000180, 1, 1, 1, "stall_exc");
        ret = 1; step(32'h0040040C, 0, 1, 1, "ret_after_exc");

        do_call(26'h0100100); step(32'h00400400, 1, 1, 1, "call_a");
        ret = 1; do_call(26'h0100200);
        step(32'h00400410, 0, 1, 1, "ret_call");
        ret = 1; branch_taken = 1; branch_offset = 16'h0003;
        step(32'h00400414, 0, 1, 1, "ret_br_unf");
        jump = 1; do_call(26'h0100100);
        step(32'h00400400, 1, 1, 1, "call_jump");
        jump = 1; jump_target = 26'h0100200;
        step(32'h00400800, 1, 1, 1, "jump_only");
        ret = 1; step(32'h00400418, 0, 1, 1, "ret_b");

        do_call(26'h0100100); step(32'h00400400, 1, 1, 1, "call_pre_rst");
        reset = 1; exception = 1; stall = 1; do_call(26'h0100200);
        step(32'h00400020, 0, 0, 0, "rst_mid");
        ret = 1; step(32'h00400024, 0, 0, 1, "ret_post_rst");

        exception = 1; step(32'h80000180, 0, 0, 1, "exc");
        jump = 1; jump_target = 26'h3FFFFFF;
        step(32'h8FFFFFFC, 0, 0, 1, "jmp_hi8");
        for (int n = 9; n < 16; n++) begin
            step({n[3:0], 28'h0000000}, 0, 0, 1, "carry");
            jump = 1; jump_target = 26'h3FFFFFF;
            step({n[3:0], 28'hFFFFFFC}, 0, 0, 1, "jmp_hi");
        end
        step(32'h00000000, 0, 0, 1, "wrap");
        step(32'h00000004, 0, 0, 1, "post_wrap");

        reset = 1; do_call(26'h0100100);
        step(32'h00400020, 0, 0, 0, "rst_call");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
